multi_rate_divider: RTL and testbench

//  Multi-channel programmable rate divider: each of CHANNELS independent down-counters emits a
//  one-clock tick every PERIOD enabled clocks, in continuous or one-shot mode. Sits between the

---
 rtl/multi_rate_divider_pkg.sv | 25 ++
 rtl/multi_rate_divider_channel.sv | 65 ++++++
 rtl/multi_rate_divider.sv | 51 +++++
 tb/tb_multi_rate_divider.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/multi_rate_divider_pkg.sv
`default_nettype none
// ============================================================================
// Package  : multi_rate_divider_pkg
// Brief    : Shared mode encoding and default sizing for the rate divider.
// Revision : 1.0 - initial release
// ============================================================================
package multi_rate_divider_pkg;

  typedef enum logic {
    MODE_CONTINUOUS = 1'b0,
    MODE_ONESHOT    = 1'b1
  } mode_e;

  localparam int c_default_width    = 26;
  localparam int c_default_channels = 4;

  // Channel index width never drops below one bit, even for a single channel.
  function automatic int clog2_min1(input int value);
    int bits;
    bits = $clog2(value);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_rate_divider_channel.sv
`default_nettype none
// ============================================================================
// Module   : rate_divider_channel
// Brief    : One programmable down-counter emitting a registered tick per period.
// Revision : 1.0 - initial release
// ============================================================================
module rate_divider_channel
  import multi_rate_divider_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clock_in,
  input  logic             clear,
  input  logic             enable,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_oneshot,
  output logic             tick,
  output logic             active
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_count;
  mode_e            r_mode;
  logic             r_active;
  logic             r_tick;

  always_ff @(posedge clock_in) begin
    if (clear) begin
      r_period <= '0;
      r_count  <= '0;
      r_mode   <= MODE_CONTINUOUS;
      r_active <= 1'b0;
      r_tick   <= 1'b0;
    end else if (load_en) begin
      r_period <= load_value;
      r_mode   <= mode_e'(load_oneshot);
      // A zero period parks the channel; count stays at zero rather than wrapping.
      r_count  <= (load_value != '0) ? load_value - c_one : '0;
      r_active <= (load_value != '0);
      r_tick   <= 1'b0;
    end else if (r_active && enable) begin
      if (r_count != '0) begin
        r_count <= r_count - c_one;
        r_tick  <= 1'b0;
      end else begin
        r_tick <= 1'b1;
        if (r_mode == MODE_ONESHOT) begin
          r_active <= 1'b0;
        end else begin
          r_count <= r_period - c_one;
        end
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick   = r_tick;
  assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/multi_rate_divider.sv
`default_nettype none
// ============================================================================
// Module   : multi_rate_divider
// Brief    : Bank of independent run-time programmable rate dividers.
// Revision : 1.0 - initial release
// ============================================================================
module multi_rate_divider
  import multi_rate_divider_pkg::*;
#(
  parameter int WIDTH    = c_default_width,
  parameter int CHANNELS = c_default_channels,
  parameter int CH_W     = clog2_min1(c_default_channels)
) (
  input  logic                clock_in,
  input  logic                clear,
  input  logic [CHANNELS-1:0] enable,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                load_oneshot,
  output logic [CHANNELS-1:0] tick_out,
  output logic [CHANNELS-1:0] ch_active
);

  logic [CHANNELS-1:0] w_load_en;

  // Only indices below CHANNELS can match, so out-of-range targets fall through.
  always_comb begin
    w_load_en = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_load_en[i] = load && (load_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
    rate_divider_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clock_in    (clock_in),
      .clear       (clear),
      .enable      (enable[g]),
      .load_en     (w_load_en[g]),
      .load_value  (load_value),
      .load_oneshot(load_oneshot),
      .tick        (tick_out[g]),
      .active      (ch_active[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_rate_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_rate_divider
// Brief    : Directed and random stimulus against a remaining-clocks model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_rate_divider;

  localparam int c_width    = 26;
  localparam int c_channels = 4;
  localparam int c_ch_w     = 3;

  logic                  clk = 1'b0;
  logic                  clear;
  logic [c_channels-1:0] enable;
  logic                  load;
  logic [c_ch_w-1:0]     load_ch;
  logic [c_width-1:0]    load_value;
  logic                  load_oneshot;
  logic [c_channels-1:0] tick_out;
  logic [c_channels-1:0] ch_active;

  int vectors = 0;
  int miscompares = 0;

  // Model: enabled clocks still to go before the next tick.
  int m_period [c_channels];
  int m_remain [c_channels];
  bit m_oneshot[c_channels];
  bit m_active [c_channels];
  bit m_tick   [c_channels];

  multi_rate_divider #(
    .WIDTH   (c_width),
    .CHANNELS(c_channels),
    .CH_W    (c_ch_w)
  ) dut (
    .clock_in    (clk),
    .clear       (clear),
    .enable      (enable),
    .load        (load),
    .load_ch     (load_ch),
    .load_value  (load_value),
    .load_oneshot(load_oneshot),
    .tick_out    (tick_out),
    .ch_active   (ch_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < c_channels; i++) begin
      if (clear) begin
        m_period[i] = 0; m_remain[i] = 0; m_oneshot[i] = 0;
        m_active[i] = 0; m_tick[i] = 0;
      end else if (load && int'(load_ch) == i) begin
        m_period[i]  = int'(load_value);
        m_remain[i]  = int'(load_value);
        m_oneshot[i] = load_oneshot;
        m_active[i]  = (load_value != 0);
        m_tick[i]    = 0;
      end else if (m_active[i] && enable[i]) begin
        m_remain[i] = m_remain[i] - 1;
        m_tick[i]   = (m_remain[i] == 0);
        if (m_remain[i] == 0) begin
          if (m_oneshot[i]) m_active[i] = 0;
          else m_remain[i] = m_period[i];
        end
      end else begin
        m_tick[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < c_channels; i++) begin
      check($sformatf("tick_out[%0d]", i), 32'(tick_out[i]), 32'(m_tick[i]));
      check($sformatf("ch_active[%0d]", i), 32'(ch_active[i]), 32'(m_active[i]));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int ch, input int value, input bit oneshot);
    load = 1'b1;
    load_ch = c_ch_w'(ch);
    load_value = c_width'(value);
    load_oneshot = oneshot;
    step();
    load = 1'b0;
  endtask

  initial begin
    clear = 1'b1; enable = '1; load = 1'b0; load_ch = '0;
    load_value = '0; load_oneshot = 1'b0;
    for (int i = 0; i < c_channels; i++) begin
      m_period[i] = 0; m_remain[i] = 0; m_oneshot[i] = 0; m_active[i] = 0; m_tick[i] = 0;
    end
    run(2);
    check("reset tick_out", 32'(tick_out), 32'h0);
    check("reset ch_active", 32'(ch_active), 32'h0);
    clear = 1'b0;

    // Clear held across a live count.
    do_load(0, 5, 1'b0);
    run(2);
    clear = 1'b1;
    run(3);
    clear = 1'b0;
    run(8);

    // Continuous P=4, P=1 and stopped P=0.
    do_load(0, 4, 1'b0);
    run(10);
    do_load(1, 1, 1'b0);
    do_load(2, 0, 1'b0);
    run(6);
    check("ch2 stopped", 32'(ch_active[2]), 32'h0);

    // One-shot with re-arm.
    do_load(3, 3, 1'b1);
    run(6);
    do_load(3, 3, 1'b1);
    run(5);

    // Enable pause mid-count.
    do_load(0, 6, 1'b0);
    run(2);
    enable[0] = 1'b0;
    run(5);
    enable[0] = 1'b1;
    run(8);

    // Reload on the terminal cycle, then an out-of-range channel.
    do_load(0, 3, 1'b0);
    run(2);
    do_load(0, 2, 1'b0);
    check("reload suppresses tick", 32'(tick_out[0]), 32'h0);
    run(6);
    do_load(5, 7, 1'b1);
    run(4);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(0, 3) == 0) ? c_channels'($urandom) : '1;
      clear = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 7) == 0);
      load_ch = c_ch_w'($urandom_range(0, 7));
      load_oneshot = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0:       load_value = '0;
        1:       load_value = '1;
        default: load_value = c_width'($urandom_range(1, 8));
      endcase
      step();
    end
    clear = 1'b0; load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
